demux_buf: RTL and testbench
============================

# demux_buf

1-to-2 buffered demultiplexer: the steering counterpart of the 2:1 `mux` in the datapath. It accepts one word stream over a valid/ready handshake and routes each word, by a per-word select bit, into one of two independent 2-entry output queues. Each queue drives its own valid/ready output port. It sits between the execute-stage result bus and its two consumers: port A is register-file writeback and port B is the store/memory path. Per-port accepted-word counters are provided for debug.

## Interface
Parameters:
- `DATA_LENGTH`, default 32: word width.
- `CNT_WIDTH`, default 16: width of each accepted-word counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high. Sampled on the rising edge of `clk`.
- `flush`  in  1: synchronous clear of both queues.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: block can accept the word on the port currently selected by `sel`.
- `sel`  in  1: destination select. 0 routes to A, 1 routes to B. Qualified by `in_valid`.
- `in_data`  in  DATA_LENGTH: input word.
- `outa_valid`  out  1: queue A head valid.
- `outa_ready`  in  1: consumer A takes the head.
- `outa_data`  out  DATA_LENGTH: queue A head word.
- `outb_valid`  out  1: queue B head valid.
- `outb_ready`  in  1: consumer B takes the head.
- `outb_data`  out  DATA_LENGTH: queue B head word.
- `cnt_a`  out  CNT_WIDTH: number of words accepted into A.
- `cnt_b`  out  CNT_WIDTH: number of words accepted into B.

## Operation
- **Queues.** Each queue is 2 entries deep with a 2-bit occupancy count (0..2). The head is presented on `outX_data`, and `outX_valid` = (count != 0).
- **in_ready.** `in_ready` = !flush && (sel ? countB < 2 : countA < 2).
  - The only combinational input-to-output path is from `sel`/`flush` to `in_ready`.
  - There is no path from `outX_ready` to `in_ready`. A full queue does not accept a word, even in a cycle where it is popped.
- **Push.** A push occurs when `in_valid && in_ready`. The word is written to the tail of the selected queue, and the selected `cnt_X` increments.
- **Pop.** A pop of queue X occurs when `outX_valid && outX_ready`. The next entry becomes the head.
- **Push and pop on the same queue in one cycle:**
  - count 1: the count stays 1 and the pushed word becomes the head.
  - count 2: cannot occur, because `in_ready` is low.
- **Independence.** Queues A and B are independent. Both may pop in the same cycle, and a push into one may coincide with a pop of the other.
- **Ordering.** Order is preserved within each port. There is no ordering relation between A and B.
- **sel when idle.** `sel` is don't-care when `in_valid` is 0. It may change every cycle.
- **Counters.** `cnt_a` and `cnt_b` wrap from 2^CNT_WIDTH-1 to 0. Neither `flush` nor wrap affects the other counter.
- **flush.**
  - Sets both occupancy counts to 0 and forces `in_ready` to 0, so no push occurs in that cycle.
  - Pops in the flush cycle are ignored.
  - Counters are not cleared.
- **Priority.** `rst` > `flush` > push/pop.

## Timing
- **Reset values** (after a rising edge with `rst`=1):
  - `outa_valid` = `outb_valid` = 0.
  - `cnt_a` = `cnt_b` = 0.
  - `outa_data` = `outb_data` = 0.
  - `in_ready` = 1 from the first cycle after reset, given `flush`=0.
- **Reset mid-operation.** Queued words are discarded and no handshake completes in the reset cycle.
- **Latency.** A word accepted at edge N appears with `outX_valid`=1 in the cycle after edge N, when the queue was empty. There is no combinational fall-through from input to output.
- **Throughput.** One word per cycle into a port whose consumer holds `outX_ready`=1 continuously. Occupancy then stays at 1.
- **Stable output.** `outX_data` is held stable while `outX_valid`=1 and `outX_ready`=0.
- **Counter timing.** Counters update on the same edge as the push and are visible the following cycle.
- **Flush timing.** `flush` at edge N gives `outa_valid` = `outb_valid` = 0 in the following cycle.

## Test plan
- **Reset, then routing and order.**
  - Stimulus: push 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0), with both readies at 1.
  - Required: A delivers 0x11 then 0x33, each one cycle after its acceptance. B delivers 0x22. Finally `cnt_a`=2 and `cnt_b`=1.
- **Full queue and backpressure.**
  - Stimulus: `outa_ready`=0. Push 0xA0, 0xA1, then attempt 0xA2 on sel 0.
  - Required: `in_ready` drops after the second push. `in_ready` stays low in the cycle `outa_ready` rises, then returns high. 0xA0, 0xA1, 0xA2 are delivered in order.
- **Cross-port non-blocking.**
  - Stimulus: fill A to 2 with `outa_ready`=0. Switch to sel 1 and push 0xB0.
  - Required: `in_ready`=1 with sel 1, and 0xB0 is delivered on B while A stays stalled.
- **Simultaneous push and pop at count 1.**
  - Stimulus: A holds 0x55 and `outa_ready`=1. Push 0x66 in the same cycle.
  - Required: 0x55 is consumed, the next cycle shows head 0x66 with `outa_valid`=1, and no word is lost or duplicated.
- **Flush.**
  - Stimulus: A holds 2 words and B holds 1. Assert `flush` together with `in_valid`=1.
  - Required: `in_ready`=0 in that cycle. Both valids are 0 in the next cycle. Counters are unchanged and the input word is not counted.
- **Counter wrap and mid-stream reset.**
  - Stimulus: with CNT_WIDTH=4, push 17 words to B, then assert `rst` while B holds 1 word.
  - Required: `cnt_b` reads 1 after wrap. After reset, `outb_valid`=0 and `cnt_b`=0.

Source files
------------

// File: rtl/demux_buf_if.sv
// Handshake bundle for demux_buf: one input stream, two output queues, debug counters.
interface demux_buf_if #(
  parameter int DATA_LENGTH = 32,
  parameter int CNT_WIDTH   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sel;
  logic [DATA_LENGTH-1:0] in_data;
  logic                   outa_valid;
  logic                   outa_ready;
  logic [DATA_LENGTH-1:0] outa_data;
  logic                   outb_valid;
  logic                   outb_ready;
  logic [DATA_LENGTH-1:0] outb_data;
  logic [CNT_WIDTH-1:0]   cnt_a;
  logic [CNT_WIDTH-1:0]   cnt_b;

  // Driver/consumer side: produces input words and output readies.
  modport master (
    output in_valid, sel, in_data, outa_ready, outb_ready,
    input  in_ready, outa_valid, outa_data, outb_valid, outb_data, cnt_a, cnt_b
  );

  // Demux side.
  modport slave (
    input  in_valid, sel, in_data, outa_ready, outb_ready,
    output in_ready, outa_valid, outa_data, outb_valid, outb_data, cnt_a, cnt_b
  );
endinterface

// File: rtl/demux_buf.sv
// 1-to-2 buffered demultiplexer: steers each input word by sel into one of two
// independent 2-entry queues (A = writeback, B = store path) with per-port counters.
module demux_buf #(
  parameter int DATA_LENGTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  demux_buf_if.slave  bus
);

  logic [DATA_LENGTH-1:0] head  [2];
  logic [DATA_LENGTH-1:0] tail  [2];
  logic [1:0]             count [2];
  logic [CNT_WIDTH-1:0]   cnt   [2];
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             out_ready;

  // in_ready looks only at sel/flush and occupancy; consumer readies never feed it,
  // so a full queue refuses a word even while it is being popped.
  always_comb begin
    out_ready    = {bus.outb_ready, bus.outa_ready};
    bus.in_ready = !flush && (bus.sel ? (count[1] != 2'd2) : (count[0] != 2'd2));
    push         = '0;
    pop          = '0;
    push[0]      = bus.in_valid && bus.in_ready && !bus.sel;
    push[1]      = bus.in_valid && bus.in_ready &&  bus.sel;
    for (int q = 0; q < 2; q++) begin
      pop[q] = (count[q] != 2'd0) && out_ready[q] && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= 2'd0;
        cnt[q]   <= '0;
      end
    end else if (flush) begin
      for (int q = 0; q < 2; q++) begin
        count[q] <= 2'd0;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        // Push+pop only happens at count 1: the new word replaces the head.
        if (push[q] && pop[q]) begin
          head[q] <= bus.in_data;
        end else if (push[q]) begin
          if (count[q] == 2'd0) begin
            head[q] <= bus.in_data;
          end else begin
            tail[q] <= bus.in_data;
          end
          count[q] <= count[q] + 2'd1;
        end else if (pop[q]) begin
          head[q]  <= tail[q];
          count[q] <= count[q] - 2'd1;
        end
        if (push[q]) begin
          cnt[q] <= cnt[q] + 1'b1;
        end
      end
    end
  end

  assign bus.outa_valid = (count[0] != 2'd0);
  assign bus.outb_valid = (count[1] != 2'd0);
  assign bus.outa_data  = head[0];
  assign bus.outb_data  = head[1];
  assign bus.cnt_a      = cnt[0];
  assign bus.cnt_b      = cnt[1];

endmodule

// File: tb/tb_demux_buf.sv
// Randomized and directed bench for demux_buf, checked against a queue-based reference model.
module tb_demux_buf;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk;
  logic rst;
  logic flush;

  demux_buf_if #(.DATA_LENGTH(DW), .CNT_WIDTH(CW)) bus ();

  demux_buf #(.DATA_LENGTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount  = 0;
  int failCount = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            mCntA;
  int            mCntB;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare every visible output with the model, then advance both.
  task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d,
                               input logic ra, input logic rb, input logic fl);
    logic expReady;
    bus.in_valid   = v;
    bus.sel        = s;
    bus.in_data    = d;
    bus.outa_ready = ra;
    bus.outb_ready = rb;
    flush          = fl;
    #1;
    expReady = !fl && (s ? (qb.size() < 2) : (qa.size() < 2));
    checkOutput("in_ready",   64'(bus.in_ready),   64'(expReady));
    checkOutput("outa_valid", 64'(bus.outa_valid), 64'(qa.size() != 0));
    checkOutput("outb_valid", 64'(bus.outb_valid), 64'(qb.size() != 0));
    if (qa.size() != 0) checkOutput("outa_data", 64'(bus.outa_data), 64'(qa[0]));
    if (qb.size() != 0) checkOutput("outb_data", 64'(bus.outb_data), 64'(qb[0]));
    checkOutput("cnt_a", 64'(bus.cnt_a), 64'(mCntA));
    checkOutput("cnt_b", 64'(bus.cnt_b), 64'(mCntB));
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ra && qa.size() != 0) void'(qa.pop_front());
      if (rb && qb.size() != 0) void'(qb.pop_front());
      if (v && expReady) begin
        if (s) begin
          qb.push_back(d);
          mCntB = (mCntB + 1) % (1 << CW);
        end else begin
          qa.push_back(d);
          mCntA = (mCntA + 1) % (1 << CW);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with a live input word to show that no handshake completes in the reset cycle.
  task automatic doReset();
    rst            = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.sel        = 1'($urandom_range(0, 1));
    bus.in_data    = $urandom;
    bus.outa_ready = 1'b1;
    bus.outb_ready = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel      = 1'b0;
    qa.delete();
    qb.delete();
    mCntA = 0;
    mCntB = 0;
    #1;
    checkOutput("rst_outa_valid", 64'(bus.outa_valid), 64'd0);
    checkOutput("rst_outb_valid", 64'(bus.outb_valid), 64'd0);
    checkOutput("rst_outa_data",  64'(bus.outa_data),  64'd0);
    checkOutput("rst_outb_data",  64'(bus.outb_data),  64'd0);
    checkOutput("rst_cnt_a",      64'(bus.cnt_a),      64'd0);
    checkOutput("rst_cnt_b",      64'(bus.cnt_b),      64'd0);
    checkOutput("rst_in_ready",   64'(bus.in_ready),   64'd1);
  endtask

  task automatic idle(input int n, input logic ra, input logic rb);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, ra, rb, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel = 1'b0;
    bus.in_data = '0;
    bus.outa_ready = 1'b0;
    bus.outb_ready = 1'b0;
    mCntA = 0;
    mCntB = 0;
    repeat (2) @(posedge clk);
    doReset();

    $display("[TB] routing and order");
    applyStimulus(1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);
    checkOutput("route_cnt_a", 64'(bus.cnt_a), 64'd2);
    checkOutput("route_cnt_b", 64'(bus.cnt_b), 64'd1);

    $display("[TB] full queue and backpressure");
    applyStimulus(1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);

    $display("[TB] cross-port non-blocking");
    applyStimulus(1'b1, 1'b0, 32'hC0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hC1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);
    idle(3, 1'b1, 1'b1);

    $display("[TB] push and pop at count 1");
    applyStimulus(1'b1, 1'b0, 32'h55, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h66, 1'b1, 1'b1, 1'b0);
    checkOutput("pp_head", 64'(bus.outa_data), 64'h66);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b1, 1'b1);

    $display("[TB] flush");
    applyStimulus(1'b1, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hF1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hF2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hF3, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_outa_valid", 64'(bus.outa_valid), 64'd0);
    checkOutput("flush_outb_valid", 64'(bus.outb_valid), 64'd0);
    idle(2, 1'b1, 1'b1);

    $display("[TB] counter wrap and mid-stream reset");
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, DW'(32'h100 + i), 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_cnt_b", 64'(bus.cnt_b), 64'd1);
    checkOutput("wrap_outb_valid", 64'(bus.outb_valid), 64'd1);
    doReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 31) == 0));
    end
    idle(3, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
